vecmat_feeder: RTL and testbench



---
 rtl/vecmat_feeder.sv | 151 +++++++++++++++
 tb/tb_vecmat_feeder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vecmat_feeder.sv
// vecmat_feeder: producer side of the 64-element dot-product unit.
// Collects (Q, K) element pairs into packed vector/matrix rows, issues the
// row with a one-cycle dp_start pulse, waits DP_LATENCY cycles, captures the
// returned score and offers it on a valid/ready result port.
//
// Optional feature macro: VECMAT_Q_REUSE_EN
//   When defined, adds input q_hold; a transfer with q_hold=1 writes only the
//   K element and leaves the Q element from the previous row in place.
//
// Handshakes (both ports): a beat transfers on a rising edge where valid and
// ready are both 1. in_ready and res_valid are functions of state only and
// never depend on in_valid or res_ready. res_data is stable while res_valid=1.
//
// fsm_state exposes the controller state for observation (0 FILL, 1 WAIT,
// 2 RESULT).

module vecmat_feeder #(
  parameter int DW         = 16,
  parameter int VECTDEPTH  = 64,
  parameter int ARRAYSIZE  = 1024,
  parameter int DP_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_vec_elem,
  input  logic [DW-1:0]        in_mat_elem,
`ifdef VECMAT_Q_REUSE_EN
  input  logic                 q_hold,
`endif
  output logic [ARRAYSIZE-1:0] vector,
  output logic [ARRAYSIZE-1:0] matrix,
  output logic                 dp_start,
  input  logic [DW-1:0]        dot_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DW-1:0]        res_data,
  output logic [15:0]          rows_done,
  output logic [1:0]           fsm_state
);

  localparam int IW = (VECTDEPTH > 1) ? $clog2(VECTDEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(VECTDEPTH - 1);
  localparam logic [7:0]    WAIT_LOAD = 8'(DP_LATENCY - 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_WAIT   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic [7:0]    wait_cnt;
  logic          take;
  logic          last_take;
  logic          vec_we;
  logic          sample;
  logic          res_take;

  assign fsm_state = state;

`ifdef VECMAT_Q_REUSE_EN
  assign vec_we = take & ~q_hold;
`else
  assign vec_we = take;
`endif

  // Next-state and handshake decode. The wait counter is held during the
  // dp_start cycle so that dot_in is sampled DP_LATENCY cycles after it.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    take      = 1'b0;
    last_take = 1'b0;
    sample    = 1'b0;
    res_take  = 1'b0;
    case (state)
      S_FILL: begin
        in_ready  = 1'b1;
        take      = in_valid;
        last_take = in_valid && (idx == LAST_IDX);
        if (last_take) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        sample = !dp_start && (wait_cnt == 8'd0);
        if (sample) state_nxt = S_RESULT;
      end
      S_RESULT: begin
        res_take = res_ready;
        if (res_ready) state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FILL;
    else       state <= state_nxt;
  end

  // Element index, latency counter and issue pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      wait_cnt <= '0;
      dp_start <= 1'b0;
    end else begin
      dp_start <= last_take;
      if (take) idx <= last_take ? '0 : idx + IW'(1);
      if (last_take) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == S_WAIT && !dp_start && wait_cnt != 8'd0) begin
        wait_cnt <= wait_cnt - 8'd1;
      end
    end
  end

  // Packed row buses; only written by accepted pairs, so they hold through
  // WAIT and RESULT and keep old contents until overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      vector <= '0;
      matrix <= '0;
    end else begin
      if (vec_we) vector[idx*DW +: DW] <= in_vec_elem;
      if (take)   matrix[idx*DW +: DW] <= in_mat_elem;
    end
  end

  // Score capture, result handshake and row counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_data  <= '0;
      res_valid <= 1'b0;
      rows_done <= '0;
    end else begin
      if (sample) begin
        res_data  <= dot_in;
        res_valid <= 1'b1;
      end else if (res_take) begin
        res_valid <= 1'b0;
        rows_done <= rows_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vecmat_feeder.sv
// Testbench for vecmat_feeder: random pair streams with a row-level reference
// model, score scoreboard queue and per-cycle monitor.
`timescale 1ns/1ps

module tb_vecmat_feeder;

  localparam int DW = 16;
  localparam int VD = 64;
  localparam int AS = 1024;
  localparam int L  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_vec_elem;
  logic [DW-1:0] in_mat_elem;
  logic          q_hold;
  logic [AS-1:0] vector;
  logic [AS-1:0] matrix;
  logic          dp_start;
  logic [DW-1:0] dot_in;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [15:0]   rows_done;
  logic [1:0]    fsm_state;

  vecmat_feeder #(.DW(DW), .VECTDEPTH(VD), .ARRAYSIZE(AS), .DP_LATENCY(L)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_vec_elem(in_vec_elem),
    .in_mat_elem(in_mat_elem),
`ifdef VECMAT_Q_REUSE_EN
    .q_hold(q_hold),
`endif
    .vector(vector),
    .matrix(matrix),
    .dp_start(dp_start),
    .dot_in(dot_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .rows_done(rows_done),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state / reference model ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_vec[VD];
  logic [DW-1:0] ref_mat[VD];
  int            xfer_idx;
  bit            fill_open;
  bit            exp_dp;
  bit            exp_dp_next;
  bit            exp_rv;
  bit            pending;
  int            wait_cyc;
  int            rows_exp;
  logic [DW-1:0] magic_val;
  int            valid_pct = 100;
  int            stall_len = 0;
  int            rows_issued = 0;

  function automatic logic [AS-1:0] pack(input logic [DW-1:0] a[VD]);
    logic [AS-1:0] r;
    r = '0;
    for (int i = 0; i < VD; i++) r[i*DW +: DW] = a[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bus(input string nm, input logic [AS-1:0] act, input logic [AS-1:0] exp);
    int e;
    n_vec++;
    if (act !== exp) begin
      e = 0;
      for (int i = VD - 1; i >= 0; i--) if (act[i*DW +: DW] !== exp[i*DW +: DW]) e = i;
      n_miss++;
      $display("FAIL %s elem %0d: got %04h expected %04h at %0t", nm, e, act[e*DW +: DW], exp[e*DW +: DW], $time);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
  endtask

  task automatic abort(input string nm);
    n_miss++;
    $display("FAIL %s: timeout waiting on DUT at %0t", nm, $time);
    summary();
    $finish;
  endtask

  // ---------------- monitor: expected behaviour per cycle ----------------
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < VD; i++) begin
        ref_vec[i] = '0;
        ref_mat[i] = '0;
      end
      xfer_idx    = 0;
      fill_open   = 1'b1;
      exp_dp      = 1'b0;
      exp_dp_next = 1'b0;
      exp_rv      = 1'b0;
      pending     = 1'b0;
      wait_cyc    = 0;
      rows_exp    = 0;
      exp_q.delete();
    end else begin
      exp_dp      = exp_dp_next;
      exp_dp_next = 1'b0;
      if (pending) begin
        wait_cyc++;
        if (wait_cyc == L + 1) begin
          exp_rv  = 1'b1;
          pending = 1'b0;
        end
      end

      chk("in_ready", {31'd0, in_ready}, {31'd0, fill_open});
      chk("dp_start", {31'd0, dp_start}, {31'd0, exp_dp});
      chk("res_valid", {31'd0, res_valid}, {31'd0, exp_rv});
      chk("rows_done", {16'd0, rows_done}, 32'(rows_exp[15:0]));
      chk_bus("vector", vector, pack(ref_vec));
      chk_bus("matrix", matrix, pack(ref_mat));
      if (exp_rv) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL res_data: got %04h with no score expected at %0t", res_data, $time);
        end else begin
          chk("res_data", {16'd0, res_data}, {16'd0, exp_q[0]});
        end
      end

      if (exp_dp) begin
        pending   = 1'b1;
        wait_cyc  = 0;
        magic_val = DW'($urandom);
        exp_q.push_back(magic_val);
      end
      if (in_valid && in_ready) begin
`ifdef VECMAT_Q_REUSE_EN
        if (!q_hold) ref_vec[xfer_idx] = in_vec_elem;
`else
        ref_vec[xfer_idx] = in_vec_elem;
`endif
        ref_mat[xfer_idx] = in_mat_elem;
        xfer_idx++;
        if (xfer_idx == VD) begin
          xfer_idx    = 0;
          fill_open   = 1'b0;
          exp_dp_next = 1'b1;
        end
      end
      if (exp_rv && res_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rows_exp++;
        exp_rv    = 1'b0;
        fill_open = 1'b1;
      end
    end
  end

  // ---------------- dot-product unit stand-in ----------------
  // The real score is present only in the cycle DP_LATENCY after dp_start.
  initial begin
    dot_in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pending && wait_cyc == L - 1) begin
        dot_in = magic_val;
      end else begin
        logic [DW-1:0] g;
        g = DW'($urandom);
        if (g == magic_val) g = ~g;
        dot_in = g;
      end
    end
  end

  // ---------------- result-port driver ----------------
  initial begin
    int cnt;
    cnt = 0;
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        res_ready = 1'b0;
        cnt = 0;
      end else if (res_valid) begin
        if (cnt >= stall_len) begin
          res_ready = 1'b1;
          cnt = 0;
        end else begin
          res_ready = 1'b0;
          cnt++;
        end
      end else begin
        res_ready = 1'($urandom_range(0, 1));
        cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pair(input logic [DW-1:0] v, input logic [DW-1:0] m, input logic h);
    int  guard;
    bit  done;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      in_vec_elem = v;
      in_mat_elem = m;
      q_hold      = h;
      in_valid    = ($urandom_range(1, 100) <= valid_pct);
      @(negedge clk);
      #1;
      if (in_valid && in_ready) done = 1'b1;
      guard++;
      if (!done && guard > 1000) abort("in_ready_wait");
    end
  endtask

  // Keeps offering junk pairs while the row is in flight; none may be taken.
  task automatic wait_result(input int target);
    int guard;
    guard = 0;
    while (rows_exp < target) begin
      @(posedge clk);
      #1;
      in_valid    = 1'b1;
      in_vec_elem = DW'($urandom);
      in_mat_elem = DW'($urandom);
      q_hold      = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      guard++;
      if (rows_exp < target && guard > 1000) abort("result_wait");
    end
    in_valid = 1'b0;
    q_hold   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    q_hold   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rows_issued = 0;
    @(negedge clk);
    #1;
    chk("reset_res_data", {16'd0, res_data}, 32'd0);
    chk("reset_rows_done", {16'd0, rows_done}, 32'd0);
  endtask

  task automatic random_row(input logic h);
    for (int i = 0; i < VD; i++) send_pair(DW'($urandom), DW'($urandom), h);
    rows_issued++;
    wait_result(rows_issued);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_vec_elem = '0;
    in_mat_elem = '0;
    q_hold      = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Directed row: consecutive transfers, long result stall.
    valid_pct = 100;
    stall_len = 20;
    for (int i = 0; i < VD; i++) send_pair(DW'(i), DW'(16'h100 + i), 1'b0);
    rows_issued++;
    wait_result(rows_issued);

    // Random rows with ~50% in_valid.
    valid_pct = 50;
    for (int r = 0; r < 2; r++) begin
      stall_len = $urandom_range(0, 5);
      random_row(1'b0);
    end

    // Reset partway through a row, then a complete row.
    for (int i = 0; i < 30; i++) send_pair(DW'($urandom), DW'($urandom), 1'b0);
    do_reset();
    stall_len = $urandom_range(0, 5);
    random_row(1'b0);

`ifdef VECMAT_Q_REUSE_EN
    // Q row reuse: second row with q_hold=1 and a poisoned Q element value.
    random_row(1'b0);
    for (int i = 0; i < VD; i++) send_pair(16'hFFFF, DW'($urandom), 1'b1);
    rows_issued++;
    wait_result(rows_issued);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    chk("score_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rows_total", {16'd0, rows_done}, 32'(rows_issued));
    summary();
    $finish;
  end

  // Global bound on run time.
  initial begin
    #500000;
    abort("global_watchdog");
  end

endmodule
